enigma_stepper: RTL

Three-rotor stepping controller that sits directly upstream of the rotor position registers in the Enigma datapath. On each accepted keypress it advances the right, middle and left rotor positions (0–25) with notch carry and the historical double-step. It emits per-rotor step pulses and the new positions to the rotor and substitution stages. It also owns the user-load path for the initial ring positions.

---
 rtl/enigma_stepper.sv | 118 +++++++++++
 1 files changed

// File: rtl/enigma_stepper.sv
// Three-rotor Enigma stepping controller with notch carry and load path.
// Define ENIGMA_DOUBLE_STEP_EN for the historical middle-rotor double-step.
module enigma_stepper #(
    parameter logic [4:0] NOTCH_R = 5'd21,
    parameter logic [4:0] NOTCH_M = 5'd4,
    parameter logic [4:0] NOTCH_L = 5'd16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [4:0] init_l,
    input  logic [4:0] init_m,
    input  logic [4:0] init_r,
    input  logic       key_valid,
    output logic       busy,
    output logic       step_l,
    output logic       step_m,
    output logic       step_r,
    output logic [4:0] pos_l,
    output logic [4:0] pos_m,
    output logic [4:0] pos_r,
    output logic       pos_valid,
    output logic       carry_out
);

    typedef enum logic [1:0] {IDLE, STEP, SETTLE} state_t;

    state_t state;
    logic   at_r;
    logic   at_m;
    logic   adv_m;
    logic   adv_l;

    function automatic logic [4:0] inc(input logic [4:0] p);
        return (p >= 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    function automatic logic [4:0] fix(input logic [4:0] p);
        return (p > 5'd25) ? 5'd0 : p;
    endfunction

    // Notch tests look only at the registered pre-step positions.
    always_comb begin
        at_r = (pos_r == NOTCH_R);
        at_m = (pos_m == NOTCH_M);
`ifdef ENIGMA_DOUBLE_STEP_EN
        adv_m = at_r | at_m;
        adv_l = at_m;
`else
        adv_m = at_r;
        adv_l = at_r & at_m;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pos_l     <= 5'd0;
            pos_m     <= 5'd0;
            pos_r     <= 5'd0;
            step_l    <= 1'b0;
            step_m    <= 1'b0;
            step_r    <= 1'b0;
            pos_valid <= 1'b0;
            carry_out <= 1'b0;
        end else if (load) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pos_l     <= fix(init_l);
            pos_m     <= fix(init_m);
            pos_r     <= fix(init_r);
            step_l    <= 1'b0;
            step_m    <= 1'b0;
            step_r    <= 1'b0;
            pos_valid <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            step_l    <= 1'b0;
            step_m    <= 1'b0;
            step_r    <= 1'b0;
            pos_valid <= 1'b0;
            carry_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        state <= STEP;
                        busy  <= 1'b1;
                    end
                end
                STEP: begin
                    pos_r  <= inc(pos_r);
                    step_r <= 1'b1;
                    if (adv_m) begin
                        pos_m  <= inc(pos_m);
                        step_m <= 1'b1;
                    end
                    if (adv_l) begin
                        pos_l     <= inc(pos_l);
                        step_l    <= 1'b1;
                        carry_out <= (pos_l == NOTCH_L);
                    end
                    state <= SETTLE;
                end
                SETTLE: begin
                    pos_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
